rr_reg_arbiter: RTL and testbench
=================================

# rr_reg_arbiter

Round-robin arbiter that shares one WIDTH-bit storage register between N requesters. Each requester raises a request with its write data. The block grants one requester at a time, captures that requester's data into the shared register, and returns a one-cycle acknowledge. It sits in front of the team's asynchronous-reset flip-flop storage and is the only writer to that register.

## Interface
- N, 4: number of requesters; N ≥ 2, not required to be a power of two.
- WIDTH, 8: width of the shared register and of each write-data slice.
- OW, $clog2(N): width of the owner index.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; asserting low clears all state immediately.
- req  in  N  per-requester request level; bit i belongs to requester i.
- wr_data  in  N*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  out  N  one-hot grant, registered.
- ack  out  N  one-hot, one-cycle write acknowledge, registered.
- q  out  WIDTH  shared register contents.
- q_valid  out  1  high once q has been written at least once since reset.
- owner  out  OW  index of the requester that last wrote q.

## Operation
- Reset values (while reset=0): state=IDLE, ptr=0, gnt=0, ack=0, q=0, q_valid=0, owner=0.
- Round-robin priority:
  - Search req starting at index ptr, ascending, wrapping from N-1 to 0.
  - The first set bit wins.
  - ptr is the index after the last granted requester, modulo N.
- FSM states are IDLE, GRANT and COOL. Illegal encodings go to IDLE.
- IDLE:
  - If req≠0, select winner i, set gnt[i]=1, go to GRANT.
  - Otherwise stay in IDLE with gnt=0.
- GRANT (exactly one cycle):
  - If req[i]=1 at the closing edge: q←wr_data slice i, q_valid←1, owner←i, ack[i]←1.
  - If req[i]=0 (withdrawn): no write, ack stays 0.
  - In both cases: gnt←0, ptr←(i+1) mod N, go to COOL.
- COOL (exactly one cycle): ack←0, go to IDLE. Requests are ignored in COOL.
- Requester contract:
  - Hold req[i] and its data stable from assertion until ack[i].
  - Drop req[i] in the ack cycle, or it re-enters arbitration as a new request.
- Changes to non-granted req bits during GRANT or COOL have no effect on the current transaction.
- gnt and ack are never high together and are each at most one-hot.

## Timing
- Edge E0, state IDLE, req≠0 sampled: gnt[i] is high in the cycle after E0 (state GRANT).
- Edge E1: q, owner and q_valid update. ack[i] is high in the cycle after E1 (state COOL).
- Edge E2: ack clears and the state returns to IDLE.
- Edge E3: the earliest next arbitration.
- Request-to-grant latency is 1 cycle. Request-to-q-update is 2 edges. Maximum throughput is one write per 3 cycles.
- A request arriving during GRANT or COOL is first sampled in IDLE; it waits at most 2 cycles plus any pending rotation.
- Worst-case wait with all N requesting continuously is (N-1)*3 cycles after the current grant.
- q is held indefinitely between writes.
- Reset asserted mid-GRANT or mid-COOL:
  - All outputs clear asynchronously, with no partial write.
  - After release, the first arbitration is from ptr=0 at the first edge that sees reset=1 with state IDLE.
- Reset released: there is no output activity until req≠0 is sampled.

## Test plan
- Reset values: hold reset=0 and toggle clk with random req → gnt=0, ack=0, q=0, q_valid=0, owner=0 throughout.
- Single write: after reset, req=4'b0100 and slice 2=8'hA5 held until ack →
  - gnt=4'b0100 for 1 cycle;
  - then ack=4'b0100 for 1 cycle, with q=8'hA5, q_valid=1, owner=2;
  - q holds 8'hA5 afterwards.
- Rotation: req=4'b1111 held continuously, each requester dropping in its ack cycle and re-raising 1 cycle later → grant order 0,1,2,3,0 at 3-cycle spacing.
- Wrap: after a grant to 2 (ptr=3), req=4'b0101 → grant 0 next, then 2. With ptr=3, req=4'b1001 → grant 3.
- Withdraw: requester 1 granted, req[1] dropped during GRANT → no ack, q unchanged, ptr advances to 2, next req=4'b0011 → grant 0.
- Reset mid-transaction: assert reset low during GRANT →
  - gnt clears immediately, q=0, q_valid=0;
  - after release with req=4'b1000, the first grant is requester 3 via the search from ptr=0.

Source files
------------

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter granting N requesters one-at-a-time write access to a
// single shared WIDTH-bit register, with a registered grant and one-cycle ack.
module rr_reg_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int OW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wr_data,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         ack,
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid,
    output logic [OW-1:0]        owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        COOL  = 2'b10
    } state_t;

    localparam logic [OW:0] N_EXT = (OW+1)'(N);

    state_t             state;
    state_t             state_next;
    logic [OW-1:0]      ptr;
    logic [OW-1:0]      ptr_next;
    logic [OW-1:0]      sel;
    logic [OW-1:0]      sel_next;
    logic [OW-1:0]      owner_next;
    logic [N-1:0]       gnt_next;
    logic [N-1:0]       ack_next;
    logic [WIDTH-1:0]   q_next;
    logic               q_valid_next;

    logic [2*N-1:0]     req_rot_wide;
    logic [N-1:0]       req_rot;
    logic               found;
    logic [OW-1:0]      offset;
    logic [OW:0]        win_sum;
    logic [OW-1:0]      win_idx;
    logic [WIDTH-1:0]   sel_data;
    logic [N-1:0]       sel_onehot;
    logic [N-1:0]       win_onehot;

    // Rotating the doubled request vector puts requester ptr at bit 0, so the
    // lowest set bit of req_rot is the round-robin winner's distance from ptr.
    assign req_rot_wide = {req, req} >> ptr;
    assign req_rot      = req_rot_wide[N-1:0];

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found  = 1'b1;
                offset = OW'(k);
            end
        end
        win_sum = {1'b0, ptr} + {1'b0, offset};
        win_idx = (win_sum >= N_EXT) ? OW'(win_sum - N_EXT) : OW'(win_sum);
    end

    always_comb begin
        sel_data   = '0;
        sel_onehot = '0;
        win_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == OW'(k)) begin
                sel_data      = wr_data[k*WIDTH +: WIDTH];
                sel_onehot[k] = 1'b1;
            end
            if (win_idx == OW'(k)) begin
                win_onehot[k] = 1'b1;
            end
        end
    end

    // Next-state and output logic; the register outputs hold unless a state
    // explicitly updates them, while gnt and ack default to low.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        sel_next     = sel;
        gnt_next     = '0;
        ack_next     = '0;
        q_next       = q;
        q_valid_next = q_valid;
        owner_next   = owner;

        case (state)
            IDLE: begin
                if (found) begin
                    sel_next   = win_idx;
                    gnt_next   = win_onehot;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if ((req & sel_onehot) != '0) begin
                    q_next       = sel_data;
                    q_valid_next = 1'b1;
                    owner_next   = sel;
                    ack_next     = sel_onehot;
                end
                ptr_next   = (sel == OW'(N - 1)) ? '0 : sel + OW'(1);
                state_next = COOL;
            end
            COOL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            sel     <= '0;
            gnt     <= '0;
            ack     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            owner   <= '0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            sel     <= sel_next;
            gnt     <= gnt_next;
            ack     <= ack_next;
            q       <= q_next;
            q_valid <= q_valid_next;
            owner   <= owner_next;
        end
    end

    assert property (@(posedge clk) disable iff (!reset)
        ((gnt & ack) == '0) && $onehot0(gnt) && $onehot0(ack));

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Scoreboard bench for rr_reg_arbiter: expected grants/writes are queued as
// traffic is driven and popped as grants and acks appear on the outputs.
module tb_rr_reg_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int OW    = 2;
    localparam int TW    = 2 * N + WIDTH + OW + 1;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [N-1:0]         req = '0;
    logic [N*WIDTH-1:0]   wr_data = '0;
    logic [N-1:0]         gnt;
    logic [N-1:0]         ack;
    logic [WIDTH-1:0]     q;
    logic                 q_valid;
    logic [OW-1:0]        owner;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    exp_t             exp_q[$];
    logic [N-1:0]     gnt_log[$];
    int               gnt_cyc[$];
    logic [N-1:0]     ack_log[$];
    logic [WIDTH-1:0] q_log[$];
    logic [OW-1:0]    owner_log[$];
    logic             qv_log[$];
    logic [WIDTH-1:0] slice [N];
    logic [WIDTH-1:0] last_data;
    logic [OW-1:0]    last_owner;

    rr_reg_arbiter #(.N(N), .WIDTH(WIDTH), .OW(OW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr_data (wr_data),
        .gnt     (gnt),
        .ack     (ack),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[0] = 1'b1;
        return v << i;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data(input logic [WIDTH-1:0] base);
        for (int i = 0; i < N; i++) begin
            slice[i] = base + WIDTH'(i * 17);
            wr_data[i*WIDTH +: WIDTH] = slice[i];
        end
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.idx  = idx;
        e.data = slice[idx];
        exp_q.push_back(e);
    endtask

    // Holds the request pattern, dropping each requester in its ack cycle and
    // optionally re-raising it one cycle later; logs grants and acks.
    task automatic run_traffic(input logic [N-1:0] pattern, input int want,
                               input bit reraise, output int seen);
        logic [N-1:0] pend;
        pend = '0;
        seen = 0;
        gnt_log.delete(); gnt_cyc.delete(); ack_log.delete();
        q_log.delete(); owner_log.delete(); qv_log.delete();
        req = pattern;
        for (int c = 0; c < want * 3 + 10 && seen < want; c++) begin
            step();
            req  = req | pend;
            pend = '0;
            if (gnt != '0) begin
                gnt_log.push_back(gnt);
                gnt_cyc.push_back(cycle);
            end
            if (ack != '0) begin
                ack_log.push_back(ack);
                q_log.push_back(q);
                owner_log.push_back(owner);
                qv_log.push_back(q_valid);
                req = req & ~ack;
                if (reraise) pend = ack;
                seen++;
            end
        end
        req = '0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        logic [TW-1:0] got;
        #2 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req     = N'($urandom);
            wr_data = {$urandom, $urandom};
            step();
            got = {gnt, ack, q, owner, q_valid};
            vectors++;
            if (got !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_hold[%0d]: got %h expected %h", i, got, {TW{1'b0}});
            end
        end
        req = '0;
        #3 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({gnt, ack, q_valid} !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_quiet[%0d]: gnt=%b ack=%b q_valid=%b expected all 0",
                         i, gnt, ack, q_valid);
            end
        end
    endtask

    task automatic test_single_write();
        exp_t e;
        exp_q.delete();
        load_data(8'h30);
        slice[2] = 8'hA5;
        wr_data[2*WIDTH +: WIDTH] = 8'hA5;
        push_exp(2);
        req = 4'b0100;
        step();
        vectors++;
        if ({gnt, ack} !== {exp_q[0].idx == 2 ? 4'b0100 : 4'b0000, 4'b0000}) begin
            miscompares++;
            $display("[TB] FAIL single_grant: gnt=%b ack=%b expected gnt=0100 ack=0000", gnt, ack);
        end
        step();
        e = exp_q.pop_front();
        vectors++;
        if ({gnt, ack, q, owner, q_valid} !== {4'b0000, onehot(e.idx), e.data, OW'(e.idx), 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL single_ack: gnt=%b ack=%b q=%h owner=%0d qv=%b expected ack=%b q=%h owner=%0d qv=1",
                     gnt, ack, q, owner, q_valid, onehot(e.idx), e.data, e.idx);
        end
        last_data  = e.data;
        last_owner = OW'(e.idx);
        req = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            wr_data = {$urandom, $urandom};
            vectors++;
            if ({gnt, ack, q, q_valid} !== {4'b0000, 4'b0000, 8'hA5, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL single_hold[%0d]: gnt=%b ack=%b q=%h qv=%b expected gnt=0 ack=0 q=a5 qv=1",
                         i, gnt, ack, q, q_valid);
            end
        end
    endtask

    task automatic test_rotation();
        int   seen;
        exp_t e;
        reset = 1'b0;
        #2 reset = 1'b1;
        exp_q.delete();
        load_data(8'h10);
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        run_traffic(4'b1111, 5, 1'b1, seen);
        vectors++;
        if (seen !== 5 || gnt_log.size() !== 5) begin
            miscompares++;
            $display("[TB] FAIL rotation_count: acks=%0d grants=%0d expected 5", seen, gnt_log.size());
        end
        for (int k = 0; k < seen && k < gnt_log.size(); k++) begin
            e = exp_q.pop_front();
            vectors++;
            if ({gnt_log[k], ack_log[k], q_log[k], owner_log[k], qv_log[k]} !==
                {onehot(e.idx), onehot(e.idx), e.data, OW'(e.idx), 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL rotation_txn[%0d]: gnt=%b ack=%b q=%h owner=%0d expected gnt/ack=%b q=%h owner=%0d",
                         k, gnt_log[k], ack_log[k], q_log[k], owner_log[k], onehot(e.idx), e.data, e.idx);
            end
            if (k > 0) begin
                vectors++;
                if (gnt_cyc[k] - gnt_cyc[k-1] !== 3) begin
                    miscompares++;
                    $display("[TB] FAIL rotation_spacing[%0d]: got %0d cycles expected 3",
                             k, gnt_cyc[k] - gnt_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int   seen;
        exp_t e;
        logic [N-1:0] pats [3];
        int           wants [3];
        exp_q.delete();
        load_data(8'h40);
        pats[0] = 4'b0100; wants[0] = 1;
        pats[1] = 4'b0101; wants[1] = 2;
        pats[2] = 4'b1001; wants[2] = 2;
        for (int p = 0; p < 3; p++) begin
            case (p)
                0: push_exp(2);
                1: begin push_exp(0); push_exp(2); end
                default: begin push_exp(3); push_exp(0); end
            endcase
            run_traffic(pats[p], wants[p], 1'b0, seen);
            vectors++;
            if (seen !== wants[p]) begin
                miscompares++;
                $display("[TB] FAIL wrap_count[%0d]: got %0d acks expected %0d", p, seen, wants[p]);
            end
            for (int k = 0; k < seen && k < gnt_log.size(); k++) begin
                e = exp_q.pop_front();
                vectors++;
                if ({gnt_log[k], ack_log[k], q_log[k], owner_log[k], qv_log[k]} !==
                    {onehot(e.idx), onehot(e.idx), e.data, OW'(e.idx), 1'b1}) begin
                    miscompares++;
                    $display("[TB] FAIL wrap_txn[%0d.%0d]: gnt=%b ack=%b q=%h owner=%0d expected gnt/ack=%b q=%h owner=%0d",
                             p, k, gnt_log[k], ack_log[k], q_log[k], owner_log[k], onehot(e.idx), e.data, e.idx);
                end
                last_data  = e.data;
                last_owner = OW'(e.idx);
            end
            exp_q.delete();
        end
    endtask

    task automatic test_withdraw();
        int   seen;
        exp_t e;
        exp_q.delete();
        req = 4'b0010;
        step();
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL withdraw_grant: gnt=%b expected 0010", gnt);
        end
        req = '0;
        step();
        vectors++;
        if ({gnt, ack, q, owner, q_valid} !== {4'b0000, 4'b0000, last_data, last_owner, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL withdraw_nowrite: gnt=%b ack=%b q=%h owner=%0d expected ack=0 q=%h owner=%0d",
                     gnt, ack, q, owner, last_data, last_owner);
        end
        step();
        push_exp(0); push_exp(1);
        run_traffic(4'b0011, 2, 1'b0, seen);
        vectors++;
        if (seen !== 2) begin
            miscompares++;
            $display("[TB] FAIL withdraw_count: got %0d acks expected 2", seen);
        end
        for (int k = 0; k < seen && k < gnt_log.size(); k++) begin
            e = exp_q.pop_front();
            vectors++;
            if ({gnt_log[k], ack_log[k], q_log[k], owner_log[k]} !==
                {onehot(e.idx), onehot(e.idx), e.data, OW'(e.idx)}) begin
                miscompares++;
                $display("[TB] FAIL withdraw_txn[%0d]: gnt=%b ack=%b q=%h owner=%0d expected gnt/ack=%b q=%h owner=%0d",
                         k, gnt_log[k], ack_log[k], q_log[k], owner_log[k], onehot(e.idx), e.data, e.idx);
            end
        end
    endtask

    task automatic test_reset_mid();
        int   seen;
        exp_t e;
        exp_q.delete();
        load_data(8'h80);
        for (int phase = 0; phase < 2; phase++) begin
            req = 4'b0100;
            step();
            vectors++;
            if (gnt !== 4'b0100) begin
                miscompares++;
                $display("[TB] FAIL resetmid_grant[%0d]: gnt=%b expected 0100", phase, gnt);
            end
            if (phase == 1) step();
            req = '0;
            #2 reset = 1'b0;
            #1;
            vectors++;
            if ({gnt, ack, q, owner, q_valid} !== '0) begin
                miscompares++;
                $display("[TB] FAIL resetmid_clear[%0d]: gnt=%b ack=%b q=%h owner=%0d qv=%b expected all 0",
                         phase, gnt, ack, q, owner, q_valid);
            end
            reset = 1'b1;
            if (phase == 0) begin
                push_exp(3);
                run_traffic(4'b1000, 1, 1'b0, seen);
            end else begin
                push_exp(1); push_exp(3);
                run_traffic(4'b1010, 2, 1'b0, seen);
            end
            vectors++;
            if (seen !== phase + 1) begin
                miscompares++;
                $display("[TB] FAIL resetmid_count[%0d]: got %0d acks expected %0d", phase, seen, phase + 1);
            end
            for (int k = 0; k < seen && k < gnt_log.size(); k++) begin
                e = exp_q.pop_front();
                vectors++;
                if ({gnt_log[k], ack_log[k], q_log[k], owner_log[k], qv_log[k]} !==
                    {onehot(e.idx), onehot(e.idx), e.data, OW'(e.idx), 1'b1}) begin
                    miscompares++;
                    $display("[TB] FAIL resetmid_txn[%0d.%0d]: gnt=%b ack=%b q=%h owner=%0d expected gnt/ack=%b q=%h owner=%0d",
                             phase, k, gnt_log[k], ack_log[k], q_log[k], owner_log[k], onehot(e.idx), e.data, e.idx);
                end
            end
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_rotation();
        test_wrap();
        test_withdraw();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
